// File: rtl/rr_mux_sched_pkg.sv
// rr_mux_sched_pkg: shared types and sizes for the round-robin mux scheduler
package rr_mux_sched_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int N_REQ = 4;
    localparam int SEL_W = $clog2(N_REQ);
endpackage

// File: rtl/rr_mux_sched_pick.sv
// rr_pick: combinational round-robin pick, first request after last in rotating order
module rr_pick
    import rr_mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] idx;
    logic [N_REQ-1:0] rot;

    always_comb begin
        start = last + 1'b1;
        rot   = (req >> start) | (req << (N_REQ - int'(start)));
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) idx = SEL_W'(i);
        pick  = idx + start;
        any   = |req;
    end
endmodule

// File: rtl/rr_mux_sched.sv
// rr_mux_sched: round-robin burst scheduler over a registered 4:1 data mux
// Optional burst extension via lock[] when RR_MUX_SCHED_LOCK_EN is defined.
module rr_mux_sched
    import rr_mux_sched_pkg::*;
#(
    parameter int DW    = 1,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data,
    input  logic                ready,
`ifdef RR_MUX_SCHED_LOCK_EN
    input  logic [N_REQ-1:0]    lock,
`endif
    output logic [SEL_W-1:0]    sel,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       q,
    output logic                q_valid
);
    localparam int BW = $clog2(BURST + 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, last_q, last_d, pick;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]    q_q, q_d;
    logic             q_valid_q, q_valid_d, any, lock_hit;
    logic [BW-1:0]    beat_q, beat_d;

    rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

`ifdef RR_MUX_SCHED_LOCK_EN
    assign lock_hit = lock[sel_q];
`else
    assign lock_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        beat_d    = beat_q;
        last_d    = last_q;
        if (state_q == IDLE) begin
            if (any) begin
                state_d = GRANT;
                sel_d   = pick;
                gnt_d   = N_REQ'(1) << pick;
                beat_d  = '0;
                last_d  = pick;
            end
        end else if (!req[sel_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
        end else if (ready) begin
            q_d       = data[sel_q*DW +: DW];
            q_valid_d = 1'b1;
            beat_d    = beat_q + 1'b1;
            // A locked owner restarts its burst instead of giving up the grant
            if (beat_d == BW'(BURST)) begin
                if (lock_hit) begin
                    beat_d = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            beat_q    <= '0;
            last_q    <= SEL_W'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
endmodule
